// File: rtl/st_pkg.sv
// Shared decode constants, state/op encodings and mask helpers for the stack sequencing engine.
package st_pkg;

    localparam logic [6:0] HDR_PUSH  = 7'b1011_010;
    localparam logic [6:0] HDR_POP   = 7'b1011_110;
    localparam logic [8:0] HDR_ADDSP = 9'b1011_0000_0;
    localparam logic [8:0] HDR_SUBSP = 9'b1011_0000_1;

    localparam logic [3:0] REG_LR = 4'd14;
    localparam logic [3:0] REG_PC = 4'd15;

    typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_DONE} state_e;
    typedef enum logic [1:0] {OP_PUSH, OP_POP, OP_SPADJ} op_e;

    function automatic logic [3:0] popcount9(input logic [8:0] m);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 9; i++) c = c + {3'b000, m[i]};
        return c;
    endfunction

endpackage

// File: rtl/st_prio_enc.sv
// Lowest-set-bit finder over the 9-bit register mask; bit 8 names LR for PUSH and PC for POP.
module st_prio_enc
    import st_pkg::*;
(
    input  logic [8:0] mask_i,
    input  op_e        op_i,
    output logic [3:0] idx_o,
    output logic       empty_o
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        idx_o = '0;
        for (int i = 8; i >= 0; i--) begin
            if (mask_i[i]) begin
                if (i == 8) idx_o = (op_i == OP_PUSH) ? REG_LR : REG_PC;
                else        idx_o = 4'(i);
            end
        end
    end

    assign empty_o = ~|mask_i;

endmodule

// File: rtl/st_seq_engine.sv
// PUSH/POP sequencer: one memory word per req/ack transfer, single SP commit at the end.
// Define ST_SEQ_SPADJ_EN to also accept ADD/SUB SP,#imm7 as a memory-free SP update.
module st_seq_engine
    import st_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WORD_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_valid,
    input  logic [15:0]       inst_in,
    output logic              inst_ready,
    output logic              st_inst,
    input  logic [ADDR_W-1:0] sp_in,
    output logic              sp_wr,
    output logic [ADDR_W-1:0] sp_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [3:0]        reg_idx,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              rf_we,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              pc_wr,
    output logic              busy,
    output logic              done
);

`ifdef ST_SEQ_SPADJ_EN
    localparam bit SPADJ_EN = 1'b1;
`else
    localparam bit SPADJ_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_BYTES);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [8:0]        mask_q, mask_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] new_sp_q, new_sp_d;
    logic              commit_q, commit_d;
    logic              pc_q, pc_d;

    logic              is_push, is_pop, is_sub, spadj_hit;
    logic [8:0]        in_mask;
    logic [3:0]        in_cnt;
    logic [ADDR_W-1:0] in_bytes, imm;
    logic [3:0]        xfer_idx;
    logic              mask_empty;

    assign is_push   = (inst_in[15:9] == HDR_PUSH);
    assign is_pop    = (inst_in[15:9] == HDR_POP);
    assign is_sub    = (inst_in[15:7] == HDR_SUBSP);
    assign spadj_hit = SPADJ_EN && ((inst_in[15:7] == HDR_ADDSP) || is_sub);
    assign st_inst   = is_push | is_pop | spadj_hit;

    assign in_mask  = inst_in[8:0];
    assign in_cnt   = popcount9(in_mask);
    assign in_bytes = STRIDE * ADDR_W'(in_cnt);
    assign imm      = ADDR_W'({inst_in[6:0], 2'b00});

    st_prio_enc u_enc (
        .mask_i  (mask_q),
        .op_i    (op_q),
        .idx_o   (xfer_idx),
        .empty_o (mask_empty)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        mask_d     = mask_q;
        addr_d     = addr_q;
        new_sp_d   = new_sp_q;
        commit_d   = commit_q;
        pc_d       = pc_q;
        inst_ready = 1'b0;
        mem_req    = 1'b0;
        rf_we      = 1'b0;
        sp_wr      = 1'b0;
        pc_wr      = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                inst_ready = 1'b1;
                if (inst_valid && st_inst) begin
                    if (spadj_hit) begin
                        op_d     = OP_SPADJ;
                        mask_d   = '0;
                        new_sp_d = is_sub ? sp_in - imm : sp_in + imm;
                        commit_d = 1'b1;
                        pc_d     = 1'b0;
                        state_d  = ST_DONE;
                    end else begin
                        op_d     = is_push ? OP_PUSH : OP_POP;
                        mask_d   = in_mask;
                        commit_d = (in_cnt != 4'd0);
                        pc_d     = is_pop & inst_in[8];
                        addr_d   = is_push ? sp_in - in_bytes : sp_in;
                        new_sp_d = is_push ? sp_in - in_bytes : sp_in + in_bytes;
                        state_d  = (in_cnt != 4'd0) ? ST_XFER : ST_DONE;
                    end
                end
            end
            ST_XFER: begin
                mem_req = ~mask_empty;
                if (mask_empty) begin
                    state_d = ST_DONE;
                end else if (mem_ack) begin
                    // A reset arriving with the ack must not let a load reach the register file.
                    rf_we   = (op_q == OP_POP) && !rst;
                    mask_d  = mask_q & (mask_q - 9'd1);
                    addr_d  = addr_q + STRIDE;
                    if (mask_d == '0) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                sp_wr   = commit_q;
                pc_wr   = commit_q & pc_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_we    = mem_req && (op_q == OP_PUSH);
    assign mem_addr  = (state_q == ST_XFER) ? addr_q : '0;
    assign reg_idx   = mem_req ? xfer_idx : '0;
    assign mem_wdata = rf_rdata;
    assign rf_wdata  = mem_rdata;
    assign sp_wdata  = new_sp_q;
    assign busy      = ~inst_ready;

    // NOTE: state registers use <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_PUSH;
            mask_q   <= '0;
            addr_q   <= '0;
            new_sp_q <= '0;
            commit_q <= 1'b0;
            pc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mask_q   <= mask_d;
            addr_q   <= addr_d;
            new_sp_q <= new_sp_d;
            commit_q <= commit_d;
            pc_q     <= pc_d;
        end
    end

endmodule

// File: tb/tb_st_seq_engine.sv
// Self-checking bench for st_seq_engine: directed cases plus randomized PUSH/POP against a list-based model.
module tb_st_seq_engine;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int WORD_BYTES = 4;

`ifdef ST_SEQ_SPADJ_EN
    localparam bit SPADJ_EN = 1'b1;
`else
    localparam bit SPADJ_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              inst_valid;
    logic [15:0]       inst_in;
    logic              inst_ready;
    logic              st_inst;
    logic [ADDR_W-1:0] sp_in;
    logic              sp_wr;
    logic [ADDR_W-1:0] sp_wdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic [3:0]        reg_idx;
    logic [DATA_W-1:0] rf_rdata;
    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;
    logic              pc_wr;
    logic              busy;
    logic              done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    st_seq_engine #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .WORD_BYTES (WORD_BYTES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_valid (inst_valid),
        .inst_in    (inst_in),
        .inst_ready (inst_ready),
        .st_inst    (st_inst),
        .sp_in      (sp_in),
        .sp_wr      (sp_wr),
        .sp_wdata   (sp_wdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .reg_idx    (reg_idx),
        .rf_rdata   (rf_rdata),
        .rf_we      (rf_we),
        .rf_wdata   (rf_wdata),
        .pc_wr      (pc_wr),
        .busy       (busy),
        .done       (done)
    );

    // Observable outputs; data fields are zeroed when their qualifying strobe is low.
    typedef struct packed {
        logic              req;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [3:0]        idx;
        logic [DATA_W-1:0] wdata;
        logic              rf_we;
        logic [DATA_W-1:0] rf_wdata;
        logic              sp_wr;
        logic [ADDR_W-1:0] sp_wdata;
        logic              pc_wr;
        logic              done;
        logic              ready;
        logic              busy;
    } obs_t;

    function automatic obs_t sample();
        obs_t o;
        o.req      = mem_req;
        o.we       = mem_we;
        o.addr     = mem_req ? mem_addr : '0;
        o.idx      = mem_req ? reg_idx : '0;
        o.wdata    = mem_we ? mem_wdata : '0;
        o.rf_we    = rf_we;
        o.rf_wdata = rf_we ? rf_wdata : '0;
        o.sp_wr    = sp_wr;
        o.sp_wdata = sp_wr ? sp_wdata : '0;
        o.pc_wr    = pc_wr;
        o.done     = done;
        o.ready    = inst_ready;
        o.busy     = busy;
        return o;
    endfunction

    function automatic obs_t idle_obs();
        obs_t e;
        e       = '0;
        e.ready = 1'b1;
        return e;
    endfunction

    // Accepts one instruction and follows it to completion; delay < 0 picks 0..2 wait cycles per word.
    task automatic run_op(input string name, input logic [15:0] inst, input logic [ADDR_W-1:0] sp,
                          input int delay);
        obs_t              exp_q[$];
        bit                ack_q[$];
        int                regs[$];
        obs_t              e, o;
        bit                push, spadj;
        int                n, d;
        logic [ADDR_W-1:0] base, new_sp, imm;

        push  = (inst[15:9] == 7'b1011010);
        spadj = (inst[15:8] == 8'hB0);
        for (int i = 0; i < 8; i++) if (inst[i]) regs.push_back(i);
        if (!spadj && inst[8]) regs.push_back(push ? 14 : 15);
        n = spadj ? 0 : regs.size();
        imm = ADDR_W'({inst[6:0], 2'b00});
        if (spadj)     new_sp = inst[7] ? sp - imm : sp + imm;
        else if (push) new_sp = sp - ADDR_W'(WORD_BYTES * n);
        else           new_sp = sp + ADDR_W'(WORD_BYTES * n);
        base = push ? new_sp : sp;

        exp_q.push_back(idle_obs());
        ack_q.push_back(1'b0);
        for (int k = 0; k < n; k++) begin
            d = (delay < 0) ? int'($urandom_range(0, 2)) : delay;
            for (int w = 0; w <= d; w++) begin
                e       = '0;
                e.req   = 1'b1;
                e.we    = push;
                e.addr  = base + ADDR_W'(WORD_BYTES * k);
                e.idx   = 4'(regs[k]);
                e.rf_we = !push && (w == d);
                exp_q.push_back(e);
                ack_q.push_back(w == d);
            end
        end
        e          = '0;
        e.done     = 1'b1;
        e.sp_wr    = spadj || (n != 0);
        e.sp_wdata = e.sp_wr ? new_sp : '0;
        e.pc_wr    = !spadj && !push && inst[8];
        exp_q.push_back(e);
        ack_q.push_back(1'b0);

        inst_in = inst;
        sp_in   = sp;
        foreach (exp_q[i]) begin
            inst_valid = (i == 0);
            mem_ack    = ack_q[i];
            rf_rdata   = $urandom;
            mem_rdata  = $urandom;
            e          = exp_q[i];
            e.busy     = !e.ready;
            if (e.we)    e.wdata    = rf_rdata;
            if (e.rf_we) e.rf_wdata = mem_rdata;
            #1;
            o = sample();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL %s inst=%h cyc=%0d got=%h want=%h", name, inst, i, o, e);
            end
            @(posedge clk);
            #1;
        end
        inst_valid = 1'b0;
        mem_ack    = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e, o;
        rst        = 1'b1;
        inst_valid = 1'b0;
        inst_in    = 16'h0000;
        sp_in      = '0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        rf_rdata   = '0;
        repeat (3) @(posedge clk);
        #1;
        e      = idle_obs();
        o      = sample();
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=%h", o, e);
        end
        total++;
        if ({mem_addr, sp_wdata, reg_idx} !== '0) begin
            bad++;
            $display("FAIL reset_regs got addr=%h sp=%h idx=%h want all 0", mem_addr, sp_wdata, reg_idx);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_decode();
        logic [15:0] hdr [8] = '{16'hB400, 16'hB500, 16'hBC00, 16'hBD00,
                                16'hB000, 16'hB080, 16'hB600, 16'h1C08};
        logic [15:0] inst;
        bit          exp_st;
        inst_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            inst = (i < 16) ? (hdr[i % 8] | 16'($urandom_range(0, 255))) : 16'($urandom);
            exp_st = (inst[15:9] == 7'b1011010) || (inst[15:9] == 7'b1011110) ||
                     (SPADJ_EN && inst[15:8] == 8'hB0);
            inst_in = inst;
            #1;
            total++;
            if (st_inst !== exp_st) begin
                bad++;
                $display("FAIL decode inst=%h got=%b want=%b", inst, st_inst, exp_st);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_directed();
        run_op("push_r0_r2_lr", 16'hB505, 32'h0000_1000, 0);
        run_op("pop_r1_pc_wait2", 16'hBD02, 32'h0000_0FF8, 2);
        run_op("push_r0_wrap", 16'hB401, 32'h0000_0000, 0);
        run_op("pop_all_wrap", 16'hBDFF, 32'hFFFF_FFF0, 1);
    endtask

    task automatic test_empty_and_ignore();
        obs_t e, o;
        run_op("push_empty", 16'hB400, 32'h0000_2000, 0);
        run_op("pop_empty", 16'hBC00, 32'h0000_2000, 0);
        for (int j = 0; j < 2; j++) begin
            inst_in    = (j == 0) ? 16'h1C08 : 16'hB07F;
            sp_in      = 32'h0000_0100;
            inst_valid = 1'b1;
            if (j == 1 && SPADJ_EN) inst_in = 16'hB600;
            for (int c = 0; c < 3; c++) begin
                #1;
                e = idle_obs();
                o = sample();
                total++;
                if (o !== e || st_inst !== 1'b0) begin
                    bad++;
                    $display("FAIL ignore inst=%h cyc=%0d st=%b got=%h want=%h", inst_in, c, st_inst, o, e);
                end
                @(posedge clk);
                #1;
            end
            inst_valid = 1'b0;
        end
    endtask

    task automatic test_spadj();
        if (SPADJ_EN) begin
            run_op("add_sp_7f", 16'hB07F, 32'h0000_0100, 0);
            run_op("sub_sp_wrap", 16'hB081, 32'h0000_0000, 0);
            for (int i = 0; i < 4; i++)
                run_op("spadj_rand", 16'hB000 | 16'($urandom_range(0, 255)), ADDR_W'($urandom), 0);
        end
    endtask

    task automatic test_rst_abort();
        obs_t e, o;
        inst_in    = 16'hBC0F;
        sp_in      = 32'h0000_2000;
        inst_valid = 1'b1;
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        mem_ack    = 1'b1;
        #1;
        total++;
        if ({mem_req, mem_addr, reg_idx, rf_we} !== {1'b1, 32'h0000_2000, 4'd0, 1'b1}) begin
            bad++;
            $display("FAIL abort_first req=%b addr=%h idx=%0d rf_we=%b want 1/2000/0/1",
                     mem_req, mem_addr, reg_idx, rf_we);
        end
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        #1;
        total++;
        if ({mem_req, mem_addr, reg_idx} !== {1'b1, 32'h0000_2004, 4'd1}) begin
            bad++;
            $display("FAIL abort_second req=%b addr=%h idx=%0d want 1/2004/1", mem_req, mem_addr, reg_idx);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            mem_ack = c[0];
            #1;
            e = idle_obs();
            o = sample();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL abort_idle cyc=%0d got=%h want=%h", c, o, e);
            end
            @(posedge clk);
            #1;
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] inst;
        for (int i = 0; i < 40; i++) begin
            inst = ($urandom_range(0, 1) != 0) ? 16'hB400 : 16'hBC00;
            inst = inst | 16'($urandom_range(0, 511));
            run_op("rand_op", inst, ADDR_W'($urandom), (i < 10) ? 0 : -1);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_directed();
        test_empty_and_ignore();
        test_spadj();
        test_rst_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
